// File: rtl/block_ram_if.sv
// Port bundle for block_ram: write port A, read port B and read data.
interface block_ram_if #(
    parameter int ADDR_W = 9,
    parameter int LANES  = 8,
    parameter int LANE_W = 9
);
    logic                      ena;
    logic [LANES-1:0]          wea;
    logic [ADDR_W-1:0]         addra;
    logic [LANES*LANE_W-1:0]   dina;
    logic                      enb;
    logic [ADDR_W-1:0]         addrb;
    logic [LANES*LANE_W-1:0]   doutb;

    modport master (
        output ena, wea, addra, dina, enb, addrb,
        input  doutb
    );

    modport slave (
        input  ena, wea, addra, dina, enb, addrb,
        output doutb
    );
endinterface

// File: rtl/block_ram.sv
// Simple dual-port byte-lane page RAM: port A writes, port B reads (read-first).
// Optional macro BLOCK_RAM_OUTREG_EN adds a second output register (latency 2).
module block_ram #(
    parameter int ADDR_W = 9,
    parameter int LANES  = 8,
    parameter int LANE_W = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    block_ram_if.slave    bus
);
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int WORD_W = LANES * LANE_W;

    // Power-up contents are zero so every valid flag starts cleared; reset never touches the array.
    logic [WORD_W-1:0] mem_r [DEPTH] = '{default: '0};
    logic [WORD_W-1:0] dout_r;
    logic              wr_en_s;

    assign wr_en_s = bus.ena & rst_n;

    // Port A: per-lane masked write into the array.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.wea[i]) begin
                    mem_r[bus.addra][i*LANE_W +: LANE_W] <= bus.dina[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Port B: array output register; non-blocking read gives pre-write data on collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r <= {WORD_W{1'b0}};
        end else if (bus.enb) begin
            dout_r <= mem_r[bus.addrb];
        end
    end

`ifdef BLOCK_RAM_OUTREG_EN
    logic [WORD_W-1:0] dout2_r;
    logic              enb_d_r;

    // Second pipeline stage, loaded one cycle after the read it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enb_d_r <= 1'b0;
            dout2_r <= {WORD_W{1'b0}};
        end else begin
            enb_d_r <= bus.enb;
            if (enb_d_r) begin
                dout2_r <= dout_r;
            end
        end
    end

    assign bus.doutb = dout2_r;
`else
    assign bus.doutb = dout_r;
`endif

endmodule

// File: tb/tb_block_ram.sv
// Scoreboard bench for block_ram: stimulus pushes expected read data, a monitor pops and compares.
module tb_block_ram;
`ifdef BLOCK_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    block_ram_if #(.ADDR_W(9), .LANES(8), .LANE_W(9)) bus ();

    block_ram #(.ADDR_W(9), .LANES(8), .LANE_W(9)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [71:0] model [512];
    logic [71:0] exp_q [$];
    logic [71:0] last_val;
    logic        v1, v2;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    endtask

    // Reference: a read returns the word as it stood before this cycle's write.
    task automatic drive(input logic e_a, input logic [7:0] w, input logic [8:0] aa,
                         input logic [71:0] d, input logic e_b, input logic [8:0] ab);
        bus.ena   = e_a;
        bus.wea   = w;
        bus.addra = aa;
        bus.dina  = d;
        bus.enb   = e_b;
        bus.addrb = ab;
        if (rst_n && e_b) exp_q.push_back(model[ab]);
        if (rst_n && e_a) begin
            for (int i = 0; i < 8; i++) begin
                if (w[i]) model[aa][i*9 +: 9] = d[i*9 +: 9];
            end
        end
    endtask

    task automatic cyc(input logic e_a, input logic [7:0] w, input logic [8:0] aa,
                       input logic [71:0] d, input logic e_b, input logic [8:0] ab);
        drive(e_a, w, aa, d, e_b, ab);
        @(negedge clk);
    endtask

    // Track which posedges performed a read so the monitor knows when data is due.
    always @(posedge clk) begin
        v1 <= bus.enb && rst_n;
        v2 <= v1 && rst_n;
    end

    // Monitor: compare due reads against the queue, otherwise doutb must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            last_val = 72'h0;
            chk("reset_hold", bus.doutb, 72'h0);
        end else if ((LAT == 2) ? v2 : v1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_read", bus.doutb, 72'hx);
            end else begin
                last_val = exp_q.pop_front();
                chk("read_data", bus.doutb, last_val);
            end
        end else begin
            chk("dout_hold", bus.doutb, last_val);
        end
    end

    localparam logic [71:0] ALL1FF = {8{9'h1FF}};
    localparam logic [71:0] FULLW  = {9'h123, 9'h145, 9'h167, 9'h189,
                                      9'h1AB, 9'h1CD, 9'h1EF, 9'h101};

    initial begin
        logic [95:0] r;
        logic [8:0]  aa, ab;
        for (int i = 0; i < 512; i++) model[i] = 72'h0;
        v1 = 1'b0;
        v2 = 1'b0;
        last_val = 72'h0;
        drive(1'b0, 8'h00, 9'd0, 72'h0, 1'b0, 9'd0);
        @(negedge clk);
        chk("reset_state", bus.doutb, 72'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 8'h00, 9'd0, 72'h0, 1'b0, 9'd0);

        // Reset mid-read clears doutb immediately and leaves memory intact.
        cyc(1'b1, 8'hFF, 9'd5, ALL1FF, 1'b0, 9'd0);
        cyc(1'b0, 8'h00, 9'd0, 72'h0, 1'b1, 9'd5);
        repeat (LAT) cyc(1'b0, 8'h00, 9'd0, 72'h0, 1'b0, 9'd0);
        drive(1'b0, 8'h00, 9'd0, 72'h0, 1'b1, 9'd5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", bus.doutb, 72'h0);
        @(negedge clk);
        cyc(1'b1, 8'hFF, 9'd5, 72'h0, 1'b1, 9'd5);
        rst_n = 1'b1;
        cyc(1'b0, 8'h00, 9'd0, 72'h0, 1'b0, 9'd0);
        cyc(1'b0, 8'h00, 9'd0, 72'h0, 1'b1, 9'd5);
        repeat (LAT + 1) cyc(1'b0, 8'h00, 9'd0, 72'h0, 1'b0, 9'd0);
        chk("retained_addr5", bus.doutb, ALL1FF);

        // Full-word write then read.
        cyc(1'b1, 8'hFF, 9'h1A3, FULLW, 1'b0, 9'd0);
        cyc(1'b0, 8'h00, 9'd0, 72'h0, 1'b1, 9'h1A3);
        repeat (LAT) cyc(1'b0, 8'h00, 9'd0, 72'h0, 1'b0, 9'd0);
        chk("full_word", bus.doutb, FULLW);

        // Byte enables on lanes 7 and 0 only.
        cyc(1'b1, 8'hFF, 9'd7, 72'h0, 1'b0, 9'd0);
        cyc(1'b1, 8'h81, 9'd7, {8{9'h1AA}}, 1'b0, 9'd0);
        cyc(1'b0, 8'h00, 9'd0, 72'h0, 1'b1, 9'd7);
        repeat (LAT) cyc(1'b0, 8'h00, 9'd0, 72'h0, 1'b0, 9'd0);
        chk("byte_enable", bus.doutb, {9'h1AA, 54'h0, 9'h1AA});

        // ena gating.
        cyc(1'b0, 8'hFF, 9'd9, ALL1FF, 1'b0, 9'd0);
        cyc(1'b0, 8'h00, 9'd0, 72'h0, 1'b1, 9'd9);
        repeat (LAT) cyc(1'b0, 8'h00, 9'd0, 72'h0, 1'b0, 9'd0);
        chk("ena_gating", bus.doutb, 72'h0);

        // Read-first collision.
        cyc(1'b1, 8'hFF, 9'd3, 72'h1, 1'b0, 9'd0);
        cyc(1'b1, 8'hFF, 9'd3, ALL1FF, 1'b1, 9'd3);
        repeat (LAT) cyc(1'b0, 8'h00, 9'd0, 72'h0, 1'b0, 9'd0);
        chk("collision_old", bus.doutb, 72'h1);
        cyc(1'b0, 8'h00, 9'd0, 72'h0, 1'b1, 9'd3);
        repeat (LAT) cyc(1'b0, 8'h00, 9'd0, 72'h0, 1'b0, 9'd0);
        chk("collision_new", bus.doutb, ALL1FF);

        // enb hold: addr 0 then four idle cycles pointing at 5, then read 5.
        cyc(1'b0, 8'h00, 9'd0, 72'h0, 1'b1, 9'd0);
        repeat (LAT + 3) cyc(1'b0, 8'h00, 9'd0, 72'h0, 1'b0, 9'd5);
        chk("enb_hold", bus.doutb, 72'h0);
        cyc(1'b0, 8'h00, 9'd0, 72'h0, 1'b1, 9'd5);
        repeat (LAT) cyc(1'b0, 8'h00, 9'd0, 72'h0, 1'b0, 9'd5);
        chk("enb_resume", bus.doutb, ALL1FF);

        // Randomised traffic on a small address window plus both range ends.
        for (int n = 0; n < 400; n++) begin
            r  = {$urandom, $urandom, $urandom};
            aa = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 9'd0 : 9'd511)
                                             : 9'($urandom_range(0, 15));
            ab = ($urandom_range(0, 3) == 0) ? aa
               : (($urandom_range(0, 7) == 0) ? 9'd511 : 9'($urandom_range(0, 15)));
            cyc(1'($urandom_range(0, 1)), 8'($urandom), aa, r[71:0],
                1'($urandom_range(0, 1)), ab);
        end
        repeat (LAT + 2) cyc(1'b0, 8'h00, 9'd0, 72'h0, 1'b0, 9'd0);
        chk("queue_drained", 72'(exp_q.size()), 72'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/block_ram.md
Name: block_ram

Overview:
- Simple dual-port byte-lane RAM holding one 512-entry page of decompressed output.
- Port A is write-only. It is used by literal and copy write-back.
- Port B is read-only. It is used by the copy-fetch pipeline and the result drain.
- Each word has 8 byte lanes of 9 bits each: {valid flag, data byte}. A per-lane write enable lets single bytes be written with their valid flags.

Parameters:
- ADDR_W, 9, address width; depth = 2**ADDR_W words.
- LANES, 8, number of byte lanes per word; also the width of wea.
- LANE_W, 9, bits per lane: bit LANE_W-1 is the valid flag, bits LANE_W-2:0 are the data byte.

Ports:
- clk  in  1  single clock for both ports
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  port A enable; a write occurs only when ena=1
- wea  in  LANES  per-lane write enable; bit i covers dina[i*LANE_W +: LANE_W]
- addra  in  ADDR_W  write address
- dina  in  LANES*LANE_W  write data; lane 7 is the most significant
- enb  in  1  port B read enable
- addrb  in  ADDR_W  read address
- doutb  out  LANES*LANE_W  read data, same lane packing as dina

Behaviour:
- Reset:
  - rst_n low clears doutb to 0 immediately, without waiting for a clock edge.
  - While rst_n is low, writes are blocked and doutb stays at 0.
  - Memory contents are not altered by reset.
- Power-up: all memory words initialise to 0, so every valid flag starts at 0.
- Write, on posedge clk with rst_n=1:
  - If ena=1, for each i with wea[i]=1, lane i of mem[addra] takes lane i of dina.
  - Lanes with wea[i]=0 keep their contents.
  - ena=0 means no write, regardless of wea.
- Read, on posedge clk with rst_n=1:
  - If enb=1, doutb loads mem[addrb]. Latency is 1 cycle and there is no additional output register.
  - If enb=0, doutb holds its previous value.
- Collision: when a write and a read hit the same address in the same cycle, the read is read-first. doutb returns the pre-write contents, and the new data is visible on the next read.
- Addressing: addresses cover the full 0..2**ADDR_W-1 range with no wrap logic and no out-of-range condition.
- Clearing: a full-page clear is performed by the caller with wea=all-ones and all valid bits 0 over 512 cycles. This block implements no clear function of its own.
- Implementation: the RAM array is inferable as block RAM. The only reset logic is on the output register(s).

Optional Feature:
- Macro BLOCK_RAM_OUTREG_EN.
- When defined:
  - An extra output pipeline register follows the array register, making read latency 2 cycles.
  - enb is delayed one cycle (enb_d). The second register loads only when enb_d=1 and otherwise holds.
  - Both registers and enb_d clear asynchronously on rst_n low.
- When undefined: latency is 1, exactly as in Behaviour.
- Write behaviour is identical in both builds.

Test Plan:
- Reset → doutb=0:
  - Write addr 5 with 0x1FF replicated in every lane, then read it back.
  - Assert rst_n=0 mid-read → doutb=0 immediately.
  - Release reset and read addr 5 again → the 0x1FF pattern returns, proving memory was retained.
- Full-word write/read:
  - ena=1, wea=FF, addra=0x1A3, dina=0x1_23_1_45_1_67_1_89_1_AB_1_CD_1_EF_1_01 (lanes {valid, byte}).
  - Next cycle enb=1, addrb=0x1A3 → one cycle later doutb equals that dina. This is 2 cycles when BLOCK_RAM_OUTREG_EN is defined.
- Byte enables:
  - Write addr 7 with all-zero data, wea=FF.
  - Then write dina=all 0x1AA lanes with wea=0x81.
  - Read addr 7 → lanes 7 and 0 are 0x1AA; lanes 6..1 are 0.
- ena gating: ena=0, wea=FF, addr 9, data nonzero → read addr 9 returns 0, the power-up value.
- Read-first collision:
  - mem[3]=0x0..01 before the cycle.
  - In one cycle, write 0x1FF in all lanes to addr 3 with enb=1, addrb=3 → doutb=0x0..01.
  - The following read of addr 3 → the 0x1FF pattern.
- enb hold:
  - Read addr 0 with enb=1 and capture the value.
  - Drop enb and change addrb to 5 → doutb unchanged for 4 cycles.
  - Raise enb → doutb equals mem[5] one cycle later.
